// File: rtl/int_source_ctrl.sv
// +--------------------------------------------------------------------------+
// | int_source_ctrl: latches edge/level peripheral interrupt requests, masks |
// | them with per-source enables and presents the lowest-index winner        |
// | through a CLAIM/COMPLETE register handshake.                             |
// | Optional macro INT_SRC_SYNC_EN adds a 2-flop input synchronizer.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module int_source_ctrl #(
  parameter int NUM_SRC = 14,
  parameter int ID_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               we_i,
  input  logic [7:0]         waddr_i,
  input  logic [31:0]        wdata_i,
  input  logic               re_i,
  input  logic [7:0]         raddr_i,
  output logic [31:0]        rdata_o,
  output logic [NUM_SRC-1:0] int_flag_o
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_CLAIMED = 1'b1;

  localparam logic [7:0] A_PENDING = 8'h00;
  localparam logic [7:0] A_ENABLE  = 8'h04;
  localparam logic [7:0] A_TRIGGER = 8'h08;
  localparam logic [7:0] A_CLAIM   = 8'h0C;

  logic [0:0]         state_q, state_d;
  logic [NUM_SRC-1:0] src_q, src_d;
  logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] trigger_q, trigger_d;
  logic [ID_W-1:0]    in_service_q, in_service_d;
  logic [NUM_SRC-1:0] int_flag_q, int_flag_d;

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] onehot_best;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [ID_W-1:0]    best_idx;
  logic [ID_W-1:0]    best_id;
  logic               best_vld;
  logic               claim_rd;
  logic               claim_fire;
  logic               complete_wr;
  logic               w1c_wr;
  logic               unused_wdata;

  assign unused_wdata = ^wdata_i[31:NUM_SRC];

`ifdef INT_SRC_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src_i;
      sync2_q <= sync1_q;
    end
  end

  assign src_d = sync2_q;
`else
  assign src_d = irq_src_i;
`endif

  assign src_prev_d = src_q;

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    req      = pending_q & enable_q;
    best_vld = 1'b0;
    best_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        best_vld = 1'b1;
        best_idx = ID_W'(i);
      end
    end
  end

  assign best_id     = best_vld ? best_idx + ID_W'(1) : '0;
  assign onehot_best = best_vld ? (NUM_SRC'(1) << best_idx) : '0;

  assign claim_rd    = re_i && (raddr_i == A_CLAIM);
  assign claim_fire  = claim_rd && (state_q == S_IDLE) && best_vld;
  assign complete_wr = we_i && (waddr_i == A_CLAIM) && (state_q == S_CLAIMED) &&
                       (wdata_i[ID_W-1:0] == in_service_q);
  assign w1c_wr      = we_i && (waddr_i == A_PENDING);

  // Clears are applied before the new edge is OR'd in, so a coincident edge wins.
  always_comb begin
    rise      = src_q & ~src_prev_q;
    clr       = (w1c_wr ? wdata_i[NUM_SRC-1:0] : '0) | (claim_fire ? onehot_best : '0);
    pending_d = (trigger_q & ((pending_q & ~clr) | rise)) | (~trigger_q & src_q);
    enable_d  = (we_i && waddr_i == A_ENABLE)  ? wdata_i[NUM_SRC-1:0] : enable_q;
    trigger_d = (we_i && waddr_i == A_TRIGGER) ? wdata_i[NUM_SRC-1:0] : trigger_q;
    in_service_d = in_service_q;
    if (claim_fire) begin
      in_service_d = best_id;
    end else if (complete_wr) begin
      in_service_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (claim_fire)  state_d = S_CLAIMED;
      S_CLAIMED: if (complete_wr) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    int_flag_d = '0;
    if (state_q == S_IDLE && !claim_fire) begin
      int_flag_d = onehot_best;
    end
    rdata_o = '0;
    case (raddr_i)
      A_PENDING: rdata_o = {{(32-NUM_SRC){1'b0}}, pending_q};
      A_ENABLE:  rdata_o = {{(32-NUM_SRC){1'b0}}, enable_q};
      A_TRIGGER: rdata_o = {{(32-NUM_SRC){1'b0}}, trigger_q};
      A_CLAIM:   rdata_o = (state_q == S_IDLE) ? {{(32-ID_W){1'b0}}, best_id} : '0;
      default:   rdata_o = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q        <= '0;
      src_prev_q   <= '0;
      pending_q    <= '0;
      enable_q     <= '0;
      trigger_q    <= '0;
      in_service_q <= '0;
      int_flag_q   <= '0;
    end else begin
      src_q        <= src_d;
      src_prev_q   <= src_prev_d;
      pending_q    <= pending_d;
      enable_q     <= enable_d;
      trigger_q    <= trigger_d;
      in_service_q <= in_service_d;
      int_flag_q   <= int_flag_d;
    end
  end

  assign int_flag_o = int_flag_q;

endmodule

`default_nettype wire

// File: tb/tb_int_source_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_int_source_ctrl: directed scoreboard bench for int_source_ctrl.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_int_source_ctrl;

`ifdef INT_SRC_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  localparam logic [7:0] A_PENDING = 8'h00;
  localparam logic [7:0] A_ENABLE  = 8'h04;
  localparam logic [7:0] A_TRIGGER = 8'h08;
  localparam logic [7:0] A_CLAIM   = 8'h0C;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] irq_src_i;
  logic        we_i;
  logic [7:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        re_i;
  logic [7:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [13:0] int_flag_o;

  logic [31:0] sb[$];
  int          n_vec = 0;
  int          n_err = 0;

  int_source_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .irq_src_i  (irq_src_i),
    .we_i       (we_i),
    .waddr_i    (waddr_i),
    .wdata_i    (wdata_i),
    .re_i       (re_i),
    .raddr_i    (raddr_i),
    .rdata_o    (rdata_o),
    .int_flag_o (int_flag_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic push(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      exp_v = sb.pop_front();
      assert (obs === exp_v) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    tick();
    we_i = 1'b0; waddr_i = 8'hFF; wdata_i = '0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    raddr_i = a;
    #1 d = rdata_o;
  endtask

  task automatic claim(output logic [31:0] d);
    raddr_i = A_CLAIM; re_i = 1'b1;
    #1 d = rdata_o;
    tick();
    re_i = 1'b0; raddr_i = 8'hFF;
  endtask

  task automatic pulse(input logic [13:0] m);
    irq_src_i = irq_src_i | m;
    tick();
    irq_src_i = irq_src_i & ~m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst = 1'b1; irq_src_i = '0; we_i = 1'b0; waddr_i = 8'hFF; wdata_i = '0;
    re_i = 1'b0; raddr_i = 8'hFF;
    tick(3);

    // Reset state
    push(32'h0); chk("rst_flag", {18'd0, int_flag_o});
    push(32'h0); rd(A_ENABLE, d);  chk("rst_enable", d);
    push(32'h0); rd(A_TRIGGER, d); chk("rst_trigger", d);
    push(32'h0); rd(8'h40, d);     chk("unmapped_rd", d);
    rst = 1'b0;
    tick();

    wr(A_ENABLE, 32'h3FFF);
    wr(A_TRIGGER, 32'h0);
    wr(8'h40, 32'hFFFF);
    push(32'h3FFF); rd(A_ENABLE, d); chk("enable_rb", d);

    // Level source 5 held high
    irq_src_i[5] = 1'b1;
    tick(LAT);
    push(32'h0);  chk("lvl_flag_early", {18'd0, int_flag_o});
    tick();
    push(32'h20); chk("lvl_flag", {18'd0, int_flag_o});
    push(32'd6);  claim(d); chk("lvl_claim", d);
    push(32'h0);  chk("lvl_flag_claimed", {18'd0, int_flag_o});
    push(32'h0);  rd(A_CLAIM, d); chk("lvl_claim_rd_busy", d);
    wr(A_CLAIM, 32'd6);
    push(32'h0);  chk("lvl_flag_after_cpl", {18'd0, int_flag_o});
    tick();
    push(32'h20); chk("lvl_represent", {18'd0, int_flag_o});
    irq_src_i[5] = 1'b0;
    tick(LAT + 1);
    push(32'h0);  chk("lvl_drop", {18'd0, int_flag_o});

    // Edge source 2
    wr(A_TRIGGER, 32'h4);
    pulse(14'h0004);
    tick(LAT - 1);
    push(32'h4);  rd(A_PENDING, d); chk("edge_pending", d);
    tick();
    push(32'h4);  chk("edge_flag", {18'd0, int_flag_o});
    push(32'd3);  claim(d); chk("edge_claim", d);
    push(32'h0);  rd(A_PENDING, d); chk("edge_pending_clr", d);
    wr(A_CLAIM, 32'd3);
    tick(2);
    push(32'h0);  chk("edge_flag_after_cpl", {18'd0, int_flag_o});

    // Two edges, lowest wins
    wr(A_TRIGGER, 32'h0206);
    pulse(14'h0202);
    tick(LAT);
    push(32'h2);   chk("prio_flag", {18'd0, int_flag_o});
    push(32'd2);   claim(d); chk("prio_claim2", d);
    wr(A_CLAIM, 32'd2);
    tick();
    push(32'h200); chk("prio_flag9", {18'd0, int_flag_o});
    push(32'd10);  claim(d); chk("prio_claim10", d);
    wr(A_CLAIM, 32'd10);

    // Wrong-ID complete ignored
    wr(A_TRIGGER, 32'h020E);
    pulse(14'h0008);
    tick(LAT);
    push(32'd4);  claim(d); chk("wrong_claim4", d);
    wr(A_CLAIM, 32'd7);
    tick();
    push(32'h0);  chk("wrong_flag", {18'd0, int_flag_o});
    push(32'h0);  claim(d); chk("wrong_claim_again", d);
    wr(A_CLAIM, 32'd4);
    pulse(14'h0008);
    tick(LAT);
    push(32'd4);  claim(d); chk("idle_again_claim", d);
    wr(A_CLAIM, 32'd4);

    // Disabled source latches; ENABLE write and W1C timing
    wr(A_ENABLE, 32'h0);
    pulse(14'h0008);
    tick(LAT);
    push(32'h0);  chk("dis_flag", {18'd0, int_flag_o});
    push(32'h8);  rd(A_PENDING, d); chk("dis_pending", d);
    wr(A_ENABLE, 32'h3FFF);
    push(32'h0);  chk("en_flag_same", {18'd0, int_flag_o});
    tick();
    push(32'h8);  chk("en_flag_next", {18'd0, int_flag_o});
    wr(A_PENDING, 32'h8);
    push(32'h0);  rd(A_PENDING, d); chk("w1c_pending", d);
    tick();
    push(32'h0);  chk("w1c_flag", {18'd0, int_flag_o});

    // Asynchronous reset while CLAIMED with levels 0 and 12 high
    wr(A_TRIGGER, 32'h0);
    irq_src_i = 14'h1001;
    tick(LAT + 1);
    push(32'd1);    claim(d); chk("rst_claim1", d);
    push(32'h1001); rd(A_PENDING, d); chk("rst_pre_pending", d);
    #2 rst = 1'b1;
    irq_src_i = '0;
    #1;
    push(32'h0); chk("arst_flag", {18'd0, int_flag_o});
    push(32'h0); rd(A_PENDING, d); chk("arst_pending", d);
    push(32'h0); rd(A_ENABLE, d);  chk("arst_enable", d);
    @(negedge clk);
    rst = 1'b0;
    tick();
    push(32'h0); claim(d); chk("arst_claim", d);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/int_source_ctrl.md
Name: int_source_ctrl

Overview:
- Peripheral-side interrupt source controller. Generates the 14-bit `int_flag` vector consumed by the core's interrupt controller.
- Collects raw requests from peripherals (timer, UART, GPIO, ...) and latches edge- or level-triggered pending bits, then masks them with per-source enables.
- Presents one winning source at a time, lowest index wins, using a claim/complete handshake over a memory-mapped register port on the peripheral bus.

Parameters:
- NUM_SRC, 14, number of interrupt sources; must equal the `INT_BUS` width.
- ID_W, 4, width of the claim/complete ID field.

Ports:
- clk  input  1  core clock
- rst  input  1  reset; one clock, asynchronous, active-high
- irq_src_i  input  NUM_SRC  raw peripheral requests
- we_i  input  1  register write strobe
- waddr_i  input  8  write byte address
- wdata_i  input  32  write data
- re_i  input  1  register read strobe; a read of CLAIM has side effects
- raddr_i  input  8  read byte address
- rdata_o  output  32  read data, combinational from `raddr_i`
- int_flag_o  output  NUM_SRC  one-hot request to the core, registered

Behaviour:
- Register map:
  - 0x00 PENDING: read gives pending[13:0]. Write-1-to-clear, applies to edge sources only.
  - 0x04 ENABLE: RW, reset 0.
  - 0x08 TRIGGER: RW, reset 0; 1 = edge-triggered, 0 = level-triggered.
  - 0x0C CLAIM/COMPLETE: a read returns the claimed ID; a write completes the ID in wdata_i[3:0].
  - Unmapped reads return 0; unmapped writes are ignored.
- Source IDs are index+1 (1..14). ID 0 means "none".
- Sampling: `src_q` is `irq_src_i` registered each cycle.
  - Edge source: pending set when src_q rises (src_q=1, previous sample 0).
  - Level source: pending = src_q, not sticky.
- State machine, 2 states:
  - IDLE: `int_flag_o` <= one-hot of the lowest set bit of (pending & ENABLE), or 0 if none.
    - A CLAIM read with `re_i` returns best ID = lowest set bit of (pending & ENABLE) + 1. If that ID is nonzero: record `in_service` = ID, clear the pending bit if the source is edge, go to CLAIMED.
    - A CLAIM read with nothing pending returns 0 and stays in IDLE.
  - CLAIMED: `int_flag_o` <= 0. A CLAIM read returns 0 with no side effect.
    - A COMPLETE write with ID == `in_service` clears `in_service` and returns to IDLE.
    - A COMPLETE write with any other ID is ignored.
- Latency: request edge sampled at edge N → pending at N+1 → `int_flag_o` valid at N+2.
- Simultaneous events:
  - A source edge and a CLAIM of that same source in one cycle: the set wins, so the bit stays pending and re-presents after complete.
  - A W1C and a new edge on the same bit in one cycle: the set wins.
  - An ENABLE write takes effect on `int_flag_o` the next cycle.
- Level source still high after complete: the request is re-presented 1 cycle after returning to IDLE.
- Disabled sources still latch pending; enabling later presents them.
- Reset, including mid-operation: state IDLE; pending, ENABLE, TRIGGER, `in_service`, `src_q` and `int_flag_o` all 0; `rdata_o` follows combinational decode.

Optional Feature:
- Macro: `INT_SRC_SYNC_EN`.
- Defined: `irq_src_i` passes through a 2-flop synchronizer before `src_q`. Latency grows from 2 to 4 cycles, all other rules unchanged. Synchronizer flops reset to 0.
- Undefined: direct single-register sampling as above.

Test Plan:
- ENABLE=0x3FFF, TRIGGER=0. Hold irq_src_i[5]=1 → `int_flag_o`=0x0020 two cycles later. CLAIM read returns 6 and `int_flag_o`=0. Write COMPLETE 6 with the source still high → `int_flag_o`=0x0020 again.
- TRIGGER[2]=1, ENABLE[2]=1, 1-cycle pulse on irq_src_i[2] → PENDING reads 0x0004. CLAIM returns 3 and PENDING reads 0. COMPLETE 3 → `int_flag_o` stays 0.
- Edges on sources 9 and 1 in the same cycle, both enabled edge → `int_flag_o`=0x0002. Claim/complete ID 2, then `int_flag_o`=0x0200 and the next CLAIM returns 10.
- In CLAIMED with ID 4: COMPLETE 7 → state unchanged and `int_flag_o` stays 0. A second CLAIM returns 0. COMPLETE 4 → IDLE.
- Assert rst mid-CLAIMED with pending=0x1001 → all outputs and registers 0 immediately (asynchronous). A CLAIM after release returns 0.
- With `INT_SRC_SYNC_EN` defined: a level source going high → `int_flag_o` asserts 4 cycles after the first sampling edge.
